decode_stream_unit: RTL and testbench

//  Parametrised 6502 decode stage. Accepts the raw byte stream from fetch over a valid/ready handshake
//  and decodes each opcode into a size (1-3) and an addressing mode. It gathers the operand bytes and

---
 rtl/decode_stream_unit.sv | 219 +++++++++++++++++++++
 tb/tb_decode_stream_unit.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stream_unit.sv
// 6502 decode stage: byte stream in, one decoded instruction packet per opcode out through a small FIFO.
// Handles redirect flush, PC tagging and a selectable policy for illegal opcodes.
module decode_stream_unit #(
  parameter int unsigned OUT_DEPTH    = 4,
  parameter int unsigned PC_W         = 16,
  parameter int unsigned ILLEGAL_MODE = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [7:0]      in_byte,
  output logic            in_ready,
  input  logic            flush,
  input  logic [PC_W-1:0] flush_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_opcode,
  output logic [15:0]     out_operand,
  output logic [1:0]      out_size,
  output logic [3:0]      out_mode,
  output logic [PC_W-1:0] out_pc,
  output logic            out_illegal,
  output logic            halted
);
  localparam int unsigned PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [3:0] M_NONE = 4'd0, M_ACC = 4'd1, M_IMM = 4'd2, M_ABS = 4'd3, M_ZP = 4'd4,
                         M_ZPX = 4'd5, M_ABSX = 4'd6, M_IMPL = 4'd7, M_REL = 4'd8, M_INDX = 4'd9,
                         M_INDY = 4'd10, M_IND = 4'd11, M_ZPY = 4'd12, M_ABSY = 4'd13;

  typedef struct packed {
    logic [7:0]      opcode;
    logic [15:0]     operand;
    logic [1:0]      size;
    logic [3:0]      mode;
    logic [PC_W-1:0] pc;
    logic            illegal;
  } pkt_t;

  typedef enum logic [1:0] {OPC, OP1, OP2} state_t;

  state_t           state;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  pkt_pc;
  logic [7:0]       opc_q;
  logic [7:0]       lo_q;
  logic [1:0]       size_q;
  logic [3:0]       mode_q;
  pkt_t             mem [OUT_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [3:0] dec_mode;
  logic [1:0] dec_size;
  logic       dec_illegal;
  logic       accept;
  logic       pop;
  logic       push;
  logic       halt_set;
  pkt_t       push_pkt;
  pkt_t       head;

  // Opcode ROM: official NMOS 6502 set, everything else is illegal.
  always_comb begin
    dec_mode    = M_NONE;
    dec_illegal = 1'b0;
    case (in_byte)
      8'h00, 8'h08, 8'h18, 8'h28, 8'h38, 8'h40, 8'h48, 8'h58, 8'h60, 8'h68, 8'h78, 8'h88, 8'h8A,
      8'h98, 8'h9A, 8'hA8, 8'hAA, 8'hB8, 8'hBA, 8'hC8, 8'hCA, 8'hD8, 8'hE8, 8'hEA, 8'hF8:
        dec_mode = M_IMPL;
      8'h0A, 8'h2A, 8'h4A, 8'h6A:
        dec_mode = M_ACC;
      8'h09, 8'h29, 8'h49, 8'h69, 8'hA0, 8'hA2, 8'hA9, 8'hC0, 8'hC9, 8'hE0, 8'hE9:
        dec_mode = M_IMM;
      8'h05, 8'h06, 8'h24, 8'h25, 8'h26, 8'h45, 8'h46, 8'h65, 8'h66, 8'h84, 8'h85, 8'h86, 8'hA4,
      8'hA5, 8'hA6, 8'hC4, 8'hC5, 8'hC6, 8'hE4, 8'hE5, 8'hE6:
        dec_mode = M_ZP;
      8'h15, 8'h16, 8'h35, 8'h36, 8'h55, 8'h56, 8'h75, 8'h76, 8'h94, 8'h95, 8'hB4, 8'hB5, 8'hD5,
      8'hD6, 8'hF5, 8'hF6:
        dec_mode = M_ZPX;
      8'h96, 8'hB6:
        dec_mode = M_ZPY;
      8'h0D, 8'h0E, 8'h20, 8'h2C, 8'h2D, 8'h2E, 8'h4C, 8'h4D, 8'h4E, 8'h6D, 8'h6E, 8'h8C, 8'h8D,
      8'h8E, 8'hAC, 8'hAD, 8'hAE, 8'hCC, 8'hCD, 8'hCE, 8'hEC, 8'hED, 8'hEE:
        dec_mode = M_ABS;
      8'h1D, 8'h1E, 8'h3D, 8'h3E, 8'h5D, 8'h5E, 8'h7D, 8'h7E, 8'h9D, 8'hBC, 8'hBD, 8'hDD, 8'hDE,
      8'hFD, 8'hFE:
        dec_mode = M_ABSX;
      8'h19, 8'h39, 8'h59, 8'h79, 8'h99, 8'hB9, 8'hBE, 8'hD9, 8'hF9:
        dec_mode = M_ABSY;
      8'h6C:
        dec_mode = M_IND;
      8'h01, 8'h21, 8'h41, 8'h61, 8'h81, 8'hA1, 8'hC1, 8'hE1:
        dec_mode = M_INDX;
      8'h11, 8'h31, 8'h51, 8'h71, 8'h91, 8'hB1, 8'hD1, 8'hF1:
        dec_mode = M_INDY;
      8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0, 8'hF0:
        dec_mode = M_REL;
      default:
        dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    case (dec_mode)
      M_ABS, M_ABSX, M_ABSY, M_IND:              dec_size = 2'd3;
      M_IMM, M_ZP, M_ZPX, M_ZPY, M_REL, M_INDX,
      M_INDY:                                    dec_size = 2'd2;
      default:                                   dec_size = 2'd1;
    endcase
  end

  assign in_ready  = !rst && !flush && !halted && (count < CNT_W'(OUT_DEPTH));
  assign accept    = in_valid && in_ready;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign halt_set  = accept && (state == OPC) && dec_illegal && (ILLEGAL_MODE != 0);

  // Packet assembly for the byte completing an instruction.
  always_comb begin
    push     = 1'b0;
    push_pkt = '0;
    if (accept) begin
      case (state)
        OPC: begin
          if (dec_illegal) begin
            push     = (ILLEGAL_MODE == 0);
            push_pkt = '{opcode: in_byte, operand: 16'h0000, size: 2'd1, mode: M_NONE,
                         pc: pc, illegal: 1'b1};
          end else if (dec_size == 2'd1) begin
            push     = 1'b1;
            push_pkt = '{opcode: in_byte, operand: 16'h0000, size: 2'd1, mode: dec_mode,
                         pc: pc, illegal: 1'b0};
          end
        end
        OP1: begin
          push     = (size_q == 2'd2);
          push_pkt = '{opcode: opc_q, operand: {8'h00, in_byte}, size: 2'd2, mode: mode_q,
                       pc: pkt_pc, illegal: 1'b0};
        end
        default: begin
          push     = 1'b1;
          push_pkt = '{opcode: opc_q, operand: {in_byte, lo_q}, size: 2'd3, mode: mode_q,
                       pc: pkt_pc, illegal: 1'b0};
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= OPC;
      pc     <= '0;
      pkt_pc <= '0;
      opc_q  <= '0;
      lo_q   <= '0;
      size_q <= '0;
      mode_q <= '0;
      halted <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(OUT_DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      state  <= OPC;
      pc     <= flush_pc;
      pkt_pc <= '0;
      opc_q  <= '0;
      lo_q   <= '0;
      size_q <= '0;
      mode_q <= '0;
      halted <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_pkt;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (halt_set) halted <= 1'b1;
      if (accept) begin
        pc <= pc + PC_W'(1);
        case (state)
          OPC: begin
            if (!dec_illegal && dec_size != 2'd1) begin
              state  <= OP1;
              opc_q  <= in_byte;
              size_q <= dec_size;
              mode_q <= dec_mode;
              pkt_pc <= pc;
            end
          end
          OP1: begin
            if (size_q == 2'd3) begin
              state <= OP2;
              lo_q  <= in_byte;
            end else begin
              state <= OPC;
            end
          end
          default: state <= OPC;
        endcase
      end
    end
  end

  assign head        = mem[rd_ptr];
  assign out_opcode  = head.opcode;
  assign out_operand = head.operand;
  assign out_size    = head.size;
  assign out_mode    = head.mode;
  assign out_pc      = head.pc;
  assign out_illegal = head.illegal;
endmodule

// File: tb/tb_decode_stream_unit.sv
// Bench for decode_stream_unit: directed scenarios plus random streams checked against a
// byte-level instruction model; a second instance covers the halt-on-illegal policy.
module tb_decode_stream_unit;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [7:0]  in_byte;
  logic [15:0] flush_pc;
  logic        in_ready, out_valid, out_illegal, halted;
  logic [7:0]  out_opcode;
  logic [15:0] out_operand, out_pc;
  logic [1:0]  out_size;
  logic [3:0]  out_mode;

  logic        rst2, flush2, in_valid2, out_ready2;
  logic [7:0]  in_byte2;
  logic [15:0] flush_pc2;
  logic        in_ready2, out_valid2, out_illegal2, halted2;
  logic [7:0]  out_opcode2;
  logic [15:0] out_operand2, out_pc2;
  logic [1:0]  out_size2;
  logic [3:0]  out_mode2;

  always #5 clk = ~clk;

  decode_stream_unit #(.OUT_DEPTH(4), .PC_W(16), .ILLEGAL_MODE(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
    .flush(flush), .flush_pc(flush_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_operand(out_operand), .out_size(out_size),
    .out_mode(out_mode), .out_pc(out_pc), .out_illegal(out_illegal), .halted(halted));

  decode_stream_unit #(.OUT_DEPTH(2), .PC_W(16), .ILLEGAL_MODE(1)) dut_halt (
    .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_byte(in_byte2), .in_ready(in_ready2),
    .flush(flush2), .flush_pc(flush_pc2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_opcode(out_opcode2), .out_operand(out_operand2), .out_size(out_size2),
    .out_mode(out_mode2), .out_pc(out_pc2), .out_illegal(out_illegal2), .halted(halted2));

  typedef struct {
    int opc; int opr; int size; int mode; int pc; int ill;
  } pkt_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   mode_tab [256];
  int   legal [$];
  pkt_t exp_q [$];
  pkt_t popped [$];
  int   part [$];
  int   m_pc, m_ppc;
  bit   last_acc;

  localparam logic [7:0] IMPL_OPS [25] = '{8'h00, 8'h08, 8'h18, 8'h28, 8'h38, 8'h40, 8'h48, 8'h58,
    8'h60, 8'h68, 8'h78, 8'h88, 8'h8A, 8'h98, 8'h9A, 8'hA8, 8'hAA, 8'hB8, 8'hBA, 8'hC8, 8'hCA,
    8'hD8, 8'hE8, 8'hEA, 8'hF8};
  localparam logic [7:0] ACC_OPS [4]  = '{8'h0A, 8'h2A, 8'h4A, 8'h6A};
  localparam logic [7:0] IMM_OPS [11] = '{8'h09, 8'h29, 8'h49, 8'h69, 8'hA0, 8'hA2, 8'hA9, 8'hC0,
    8'hC9, 8'hE0, 8'hE9};
  localparam logic [7:0] ZP_OPS [21]  = '{8'h05, 8'h06, 8'h24, 8'h25, 8'h26, 8'h45, 8'h46, 8'h65,
    8'h66, 8'h84, 8'h85, 8'h86, 8'hA4, 8'hA5, 8'hA6, 8'hC4, 8'hC5, 8'hC6, 8'hE4, 8'hE5, 8'hE6};
  localparam logic [7:0] ZPX_OPS [16] = '{8'h15, 8'h16, 8'h35, 8'h36, 8'h55, 8'h56, 8'h75, 8'h76,
    8'h94, 8'h95, 8'hB4, 8'hB5, 8'hD5, 8'hD6, 8'hF5, 8'hF6};
  localparam logic [7:0] ZPY_OPS [2]  = '{8'h96, 8'hB6};
  localparam logic [7:0] ABS_OPS [23] = '{8'h0D, 8'h0E, 8'h20, 8'h2C, 8'h2D, 8'h2E, 8'h4C, 8'h4D,
    8'h4E, 8'h6D, 8'h6E, 8'h8C, 8'h8D, 8'h8E, 8'hAC, 8'hAD, 8'hAE, 8'hCC, 8'hCD, 8'hCE, 8'hEC,
    8'hED, 8'hEE};
  localparam logic [7:0] ABSX_OPS [15] = '{8'h1D, 8'h1E, 8'h3D, 8'h3E, 8'h5D, 8'h5E, 8'h7D, 8'h7E,
    8'h9D, 8'hBC, 8'hBD, 8'hDD, 8'hDE, 8'hFD, 8'hFE};
  localparam logic [7:0] ABSY_OPS [9] = '{8'h19, 8'h39, 8'h59, 8'h79, 8'h99, 8'hB9, 8'hBE, 8'hD9,
    8'hF9};
  localparam logic [7:0] INDX_OPS [8] = '{8'h01, 8'h21, 8'h41, 8'h61, 8'h81, 8'hA1, 8'hC1, 8'hE1};
  localparam logic [7:0] INDY_OPS [8] = '{8'h11, 8'h31, 8'h51, 8'h71, 8'h91, 8'hB1, 8'hD1, 8'hF1};
  localparam logic [7:0] REL_OPS [8]  = '{8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0, 8'hF0};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic build_table();
    for (int i = 0; i < 256; i++) mode_tab[i] = -1;
    foreach (IMPL_OPS[i]) mode_tab[IMPL_OPS[i]] = 7;
    foreach (ACC_OPS[i])  mode_tab[ACC_OPS[i]]  = 1;
    foreach (IMM_OPS[i])  mode_tab[IMM_OPS[i]]  = 2;
    foreach (ABS_OPS[i])  mode_tab[ABS_OPS[i]]  = 3;
    foreach (ZP_OPS[i])   mode_tab[ZP_OPS[i]]   = 4;
    foreach (ZPX_OPS[i])  mode_tab[ZPX_OPS[i]]  = 5;
    foreach (ABSX_OPS[i]) mode_tab[ABSX_OPS[i]] = 6;
    foreach (REL_OPS[i])  mode_tab[REL_OPS[i]]  = 8;
    foreach (INDX_OPS[i]) mode_tab[INDX_OPS[i]] = 9;
    foreach (INDY_OPS[i]) mode_tab[INDY_OPS[i]] = 10;
    mode_tab[8'h6C] = 11;
    foreach (ZPY_OPS[i])  mode_tab[ZPY_OPS[i]]  = 12;
    foreach (ABSY_OPS[i]) mode_tab[ABSY_OPS[i]] = 13;
    for (int i = 0; i < 256; i++) if (mode_tab[i] >= 0) legal.push_back(i);
  endtask

  // Instruction length follows from how many address bytes the mode needs.
  function automatic int size_of(input int mode);
    if (mode == 1 || mode == 7) return 1;
    if (mode == 3 || mode == 6 || mode == 11 || mode == 13) return 3;
    return 2;
  endfunction

  task automatic model_byte(input int b);
    pkt_t p;
    if (part.size() == 0) m_ppc = m_pc;
    part.push_back(b);
    if (mode_tab[part[0]] < 0) begin
      p = '{opc: part[0], opr: 0, size: 1, mode: 0, pc: m_ppc, ill: 1};
      exp_q.push_back(p);
      part.delete();
    end else if (part.size() == size_of(mode_tab[part[0]])) begin
      p.opc  = part[0];
      p.size = part.size();
      p.mode = mode_tab[part[0]];
      p.pc   = m_ppc;
      p.ill  = 0;
      p.opr  = (p.size >= 2 ? part[1] : 0) + (p.size == 3 ? part[2] * 256 : 0);
      exp_q.push_back(p);
      part.delete();
    end
    m_pc = (m_pc + 1) % 65536;
  endtask

  // One clock of the main instance: drive, compare against the model, then advance the model.
  task automatic step(input bit r, input bit f, input int fpc, input bit v, input int b,
                      input bit ordy);
    bit   exp_ready;
    pkt_t obs;
    @(negedge clk);
    rst = r; flush = f; flush_pc = 16'(fpc); in_valid = v; in_byte = 8'(b); out_ready = ordy;
    #1;
    last_acc = 1'b0;
    if (r) begin
      check_eq("rst_in_ready", 32'(in_ready), 32'd0);
      exp_q.delete(); part.delete(); m_pc = 0;
    end else begin
      exp_ready = !f && (exp_q.size() < 4);
      check_eq("in_ready", 32'(in_ready), 32'(exp_ready));
      check_eq("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check_eq("halted", 32'(halted), 32'd0);
      if (exp_q.size() != 0) begin
        check_eq("opcode", 32'(out_opcode), 32'(exp_q[0].opc));
        check_eq("operand", 32'(out_operand), 32'(exp_q[0].opr));
        check_eq("size", 32'(out_size), 32'(exp_q[0].size));
        check_eq("mode", 32'(out_mode), 32'(exp_q[0].mode));
        check_eq("pc", 32'(out_pc), 32'(exp_q[0].pc));
        check_eq("illegal", 32'(out_illegal), 32'(exp_q[0].ill));
      end
      if (out_valid && ordy && !f) begin
        obs = '{opc: int'(out_opcode), opr: int'(out_operand), size: int'(out_size),
                mode: int'(out_mode), pc: int'(out_pc), ill: int'(out_illegal)};
        popped.push_back(obs);
      end
      if (f) begin
        exp_q.delete(); part.delete(); m_pc = fpc;
      end else begin
        if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
        if (v && exp_ready) begin
          model_byte(b);
          last_acc = 1'b1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1);
  endtask

  task automatic step2(input bit r, input bit f, input int fpc, input bit v, input int b,
                       input bit ordy);
    @(negedge clk);
    rst2 = r; flush2 = f; flush_pc2 = 16'(fpc); in_valid2 = v; in_byte2 = 8'(b); out_ready2 = ordy;
    #1;
  endtask

  initial begin
    int sent;
    build_table();
    rst2 = 1'b1; flush2 = 1'b0; flush_pc2 = '0; in_valid2 = 1'b0; in_byte2 = '0; out_ready2 = 1'b0;

    // reset
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    check_eq("t1_in_ready", 32'(in_ready), 32'd1);
    check_eq("t1_out_valid", 32'(out_valid), 32'd0);
    check_eq("t1_opcode_zero", 32'(out_opcode), 32'd0);
    check_eq("t1_pc_zero", 32'(out_pc), 32'd0);

    // LDA immediate after redirect
    step(0, 1, 'h8000, 0, 0, 1);
    step(0, 0, 0, 1, 'hA9, 1);
    step(0, 0, 0, 1, 'h42, 1);
    idle(3);
    check_eq("t2_count", 32'(popped.size()), 32'd1);
    if (popped.size() == 1) begin
      check_eq("t2_opc", 32'(popped[0].opc), 32'hA9);
      check_eq("t2_opr", 32'(popped[0].opr), 32'h0042);
      check_eq("t2_size", 32'(popped[0].size), 32'd2);
      check_eq("t2_mode", 32'(popped[0].mode), 32'd2);
      check_eq("t2_pc", 32'(popped[0].pc), 32'h8000);
    end

    // JMP absolute with valid gaps
    popped.delete();
    step(0, 0, 0, 1, 'h4C, 1); idle(1);
    step(0, 0, 0, 1, 'h34, 1); idle(2);
    step(0, 0, 0, 1, 'h12, 1); idle(3);
    check_eq("t3_count", 32'(popped.size()), 32'd1);
    if (popped.size() == 1) begin
      check_eq("t3_opr", 32'(popped[0].opr), 32'h1234);
      check_eq("t3_size", 32'(popped[0].size), 32'd3);
      check_eq("t3_mode", 32'(popped[0].mode), 32'd3);
    end

    // FIFO full backpressure, then drain
    popped.delete();
    sent = 0;
    for (int c = 0; c < 30; c++) begin
      step(0, 0, 0, sent < 6, 'hEA, c >= 12);
      if (last_acc) sent++;
    end
    check_eq("t4_sent", 32'(sent), 32'd6);
    check_eq("t4_count", 32'(popped.size()), 32'd6);
    for (int i = 1; i < popped.size(); i++)
      check_eq("t4_pc_seq", 32'(popped[i].pc), 32'((popped[0].pc + i) % 65536));

    // flush mid-instruction drops the partial LDA abs
    popped.delete();
    step(0, 0, 0, 1, 'hAD, 1);
    step(0, 0, 0, 1, 'h00, 1);
    step(0, 1, 'hC000, 1, 'h34, 1);
    step(0, 0, 0, 1, 'hEA, 1);
    idle(3);
    check_eq("t5_count", 32'(popped.size()), 32'd1);
    if (popped.size() == 1) begin
      check_eq("t5_opc", 32'(popped[0].opc), 32'hEA);
      check_eq("t5_pc", 32'(popped[0].pc), 32'hC000);
    end

    // illegal opcode emitted as a 1-byte packet
    popped.delete();
    step(0, 0, 0, 1, 'h02, 1);
    step(0, 0, 0, 1, 'hEA, 1);
    idle(3);
    check_eq("t6_count", 32'(popped.size()), 32'd2);
    if (popped.size() == 2) begin
      check_eq("t6_ill", 32'(popped[0].ill), 32'd1);
      check_eq("t6_ill_size", 32'(popped[0].size), 32'd1);
      check_eq("t6_next_opc", 32'(popped[1].opc), 32'hEA);
    end

    // PC wrap across JSR
    popped.delete();
    step(0, 1, 'hFFFF, 0, 0, 1);
    step(0, 0, 0, 1, 'h20, 1);
    step(0, 0, 0, 1, 'h00, 1);
    step(0, 0, 0, 1, 'h80, 1);
    step(0, 0, 0, 1, 'hEA, 1);
    idle(3);
    check_eq("wrap_count", 32'(popped.size()), 32'd2);
    if (popped.size() == 2) begin
      check_eq("wrap_pc0", 32'(popped[0].pc), 32'hFFFF);
      check_eq("wrap_pc1", 32'(popped[1].pc), 32'h0002);
    end

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      int b;
      b = ($urandom_range(0, 1) == 1) ? legal[$urandom_range(0, legal.size() - 1)]
                                      : int'($urandom_range(0, 255));
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 59) == 0), int'($urandom_range(0, 65535)),
           ($urandom_range(0, 9) < 7), b, ($urandom_range(0, 9) < 6));
    end
    idle(6);

    // halt-on-illegal instance
    step2(1, 0, 0, 0, 0, 0);
    step2(1, 0, 0, 0, 0, 0);
    step2(0, 0, 0, 1, 'hEA, 0);
    check_eq("h_in_ready0", 32'(in_ready2), 32'd1);
    check_eq("h_halted0", 32'(halted2), 32'd0);
    step2(0, 0, 0, 1, 'h02, 0);
    check_eq("h_in_ready1", 32'(in_ready2), 32'd1);
    check_eq("h_valid1", 32'(out_valid2), 32'd1);
    step2(0, 0, 0, 1, 'hEA, 1);
    check_eq("h_halted2", 32'(halted2), 32'd1);
    check_eq("h_in_ready2", 32'(in_ready2), 32'd0);
    check_eq("h_drain_opc", 32'(out_opcode2), 32'hEA);
    step2(0, 0, 0, 1, 'hEA, 1);
    check_eq("h_no_pkt", 32'(out_valid2), 32'd0);
    check_eq("h_in_ready3", 32'(in_ready2), 32'd0);
    step2(0, 1, 'h1234, 1, 'hEA, 1);
    check_eq("h_flush_ready", 32'(in_ready2), 32'd0);
    step2(0, 0, 0, 1, 'hEA, 1);
    check_eq("h_unhalt", 32'(halted2), 32'd0);
    check_eq("h_in_ready4", 32'(in_ready2), 32'd1);
    check_eq("h_valid4", 32'(out_valid2), 32'd0);
    step2(0, 0, 0, 0, 0, 0);
    check_eq("h_valid5", 32'(out_valid2), 32'd1);
    check_eq("h_opc5", 32'(out_opcode2), 32'hEA);
    check_eq("h_pc5", 32'(out_pc2), 32'h1234);
    check_eq("h_ill5", 32'(out_illegal2), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
